// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports and two write
// ports, optional hardwired zero register, write-to-read bypass, optional
// registered read and a one-register-per-cycle bulk clear engine.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          READ_REG = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]      rd_addr,
  output logic [NUM_RD*WIDTH-1:0]              rd_data,
  input  logic [1:0]                           wr_en,
  input  logic [2*$clog2(DEPTH)-1:0]           wr_addr,
  input  logic [2*WIDTH-1:0]                   wr_data,
  input  logic                                 clear_req,
  output logic                                 clear_busy,
  output logic                                 clear_done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t              state;
  logic [AW-1:0]       idx;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic [AW-1:0]       wa [2];
  logic [WIDTH-1:0]    wd [2];
  logic [1:0]          wr_ok;
  logic                wr_open;
  logic [NUM_RD*WIDTH-1:0] rd_comb;

  // Address is inside the array and not the hardwired zero register
  function automatic logic addr_legal(input logic [AW-1:0] a);
    logic in_range;
    in_range = (AW+1)'(a) < (AW+1)'(DEPTH);
    return in_range && !(ZERO_REG && (a == '0));
  endfunction

  // Writes (and bypass) are blocked only while the clear engine is sweeping
  assign wr_open = (state != S_CLEAR);

  // Per write port: unpack address/data and qualify the enable
  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign wa[j]    = wr_addr[j*AW +: AW];
    assign wd[j]    = wr_data[j*WIDTH +: WIDTH];
    assign wr_ok[j] = wr_en[j] && wr_open && addr_legal(wa[j]);
  end

  // Clear engine: IDLE -> CLEAR (DEPTH cycles) -> DONE (one cycle) -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= S_CLEAR;
            idx        <= '0;
            clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (idx == AW'(DEPTH - 1)) begin
            state      <= S_DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage: clear sweep has the array to itself; otherwise port 1 written last so it wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (state == S_CLEAR) begin
      mem[idx] <= '0;
    end else begin
      if (wr_ok[0]) mem[wa[0]] <= wd[0];
      if (wr_ok[1]) mem[wa[1]] <= wd[1];
    end
  end

  // Read ports: masked array read, then bypass with port-1 priority
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = rd_addr[i*AW +: AW];

    // Select stored value or in-flight write data for this port
    always_comb begin
      rv = '0;
      if (addr_legal(ra)) rv = mem[ra];
      if (BYPASS && wr_ok[0] && (wa[0] == ra)) rv = wd[0];
      if (BYPASS && wr_ok[1] && (wa[1] == ra)) rv = wd[1];
    end

    assign rd_comb[i*WIDTH +: WIDTH] = rv;
  end

  if (READ_REG) begin : g_rd_reg
    logic [NUM_RD*WIDTH-1:0] rd_q;

    // One-cycle read latency: capture this cycle's read result
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_comb;
    end

    assign rd_data = rd_q;
  end else begin : g_rd_comb
    assign rd_data = rd_comb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: three instances share stimulus
//   u_a: defaults (DEPTH 32, zero reg, bypass, combinational read)
//   u_b: DEPTH 24, no bypass, combinational read
//   u_c: defaults but registered read
module tb_regfile_mp;

  localparam int unsigned AW = 5;
  localparam int unsigned W  = 32;

  logic          clk;
  logic          reset;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*W-1:0]  wr_data;
  logic          clear_req;

  logic [2*W-1:0] rd_a, rd_b, rd_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mp u_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_busy(busy_a), .clear_done(done_a)
  );

  regfile_mp #(.DEPTH(24), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_busy(busy_b), .clear_done(done_b)
  );

  regfile_mp #(.READ_REG(1'b1)) u_c (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_busy(busy_c), .clear_done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*W +: W]   = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    int cnt_busy_a, cnt_busy_b, cnt_done_a, cnt_done_b;
    logic wrote_done;

    reset     = 1'b0;
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;

    // Reset state
    step();
    step();
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_rd_c",   rd_c,        64'd0);
    check("rst_rd_a",   rd_a,        64'd0);
    reset = 1'b1;
    step();

    // Basic write, same-cycle bypass vs. old value
    wr(0, 5, 32'hDEADBEEF);
    rd(0, 5);
    rd(1, 6);
    #1;
    check("byp_a_5",   64'(rd_a[31:0]), 64'hDEADBEEF);
    check("nobyp_b_5", 64'(rd_b[31:0]), 64'd0);
    step();
    wr_en = '0;
    #1;
    check("wr_a_5", 64'(rd_a[31:0]),  64'hDEADBEEF);
    check("wr_a_6", 64'(rd_a[63:32]), 64'd0);
    check("wr_b_5", 64'(rd_b[31:0]),  64'hDEADBEEF);
    check("byp_c_5", 64'(rd_c[31:0]), 64'hDEADBEEF);

    // Registered read latency
    rd(0, 6);
    step();
    rd(0, 5);
    #1;
    check("lat_c_old", 64'(rd_c[31:0]), 64'd0);
    step();
    check("lat_c_new", 64'(rd_c[31:0]), 64'hDEADBEEF);

    // Zero register
    wr(0, 0, 32'h1234);
    rd(0, 0);
    #1;
    check("zero_byp_a", 64'(rd_a[31:0]), 64'd0);
    step();
    wr_en = '0;
    #1;
    check("zero_a", 64'(rd_a[31:0]), 64'd0);
    check("zero_b", 64'(rd_b[31:0]), 64'd0);

    // Out-of-range address on the DEPTH-24 instance
    wr(0, 30, 32'h7777);
    step();
    wr_en = '0;
    rd(0, 30);
    rd(1, 6);
    #1;
    check("oor_a_30", 64'(rd_a[31:0]),  64'h7777);
    check("oor_b_30", 64'(rd_b[31:0]),  64'd0);
    check("oor_b_6",  64'(rd_b[63:32]), 64'd0);
    rd(1, 5);
    #1;
    check("oor_b_5",  64'(rd_b[63:32]), 64'hDEADBEEF);

    // Write collision: port 1 wins
    step();
    wr(0, 7, 32'hAAAA);
    wr(1, 7, 32'h5555);
    rd(0, 7);
    #1;
    check("coll_byp_a", 64'(rd_a[31:0]), 64'h5555);
    step();
    wr_en = '0;
    #1;
    check("coll_a", 64'(rd_a[31:0]), 64'h5555);
    check("coll_b", 64'(rd_b[31:0]), 64'h5555);

    // Bypass on both read ports from write port 1
    wr(1, 3, 32'hCAFE);
    rd(0, 3);
    rd(1, 3);
    #1;
    check("cafe_a0", 64'(rd_a[31:0]),  64'hCAFE);
    check("cafe_a1", 64'(rd_a[63:32]), 64'hCAFE);
    check("cafe_b_old", 64'(rd_b[31:0]), 64'd0);
    step();
    wr_en = '0;
    #1;
    check("cafe_b_new", 64'(rd_b[31:0]), 64'hCAFE);

    // Fill registers with their index
    for (int a = 1; a < 32; a++) begin
      wr(0, a, 32'(a));
      step();
    end
    wr_en = '0;
    rd(0, 31);
    rd(1, 23);
    #1;
    check("fill_a_31", 64'(rd_a[31:0]),  64'd31);
    check("fill_b_23", 64'(rd_b[63:32]), 64'd23);

    // Bulk clear: count busy/done, write during busy, write in DONE
    clear_req = 1'b1;
    step();
    clear_req  = 1'b0;
    cnt_busy_a = 0;
    cnt_busy_b = 0;
    cnt_done_a = 0;
    cnt_done_b = 0;
    wrote_done = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (busy_a) cnt_busy_a++;
      if (busy_b) cnt_busy_b++;
      if (done_b) cnt_done_b++;
      wr_en = '0;
      if (n == 20) wr(0, 9, 32'h99);
      if (done_a) begin
        cnt_done_a++;
        if (!wrote_done) begin
          wr(0, 12, 32'hBEEF);
          wrote_done = 1'b1;
        end
      end
      step();
    end
    wr_en = '0;
    check("clr_busy_a", 64'(cnt_busy_a), 64'd32);
    check("clr_done_a", 64'(cnt_done_a), 64'd1);
    check("clr_busy_b", 64'(cnt_busy_b), 64'd24);
    check("clr_done_b", 64'(cnt_done_b), 64'd1);
    for (int a = 0; a < 32; a++) begin
      rd(0, a);
      #1;
      check($sformatf("clr_a[%0d]", a), 64'(rd_a[31:0]), (a == 12) ? 64'hBEEF : 64'd0);
      check($sformatf("clr_b[%0d]", a), 64'(rd_b[31:0]), (a == 12) ? 64'hBEEF : 64'd0);
      step();
    end

    // Reset in the middle of a clear
    wr(0, 4, 32'h44);
    wr(1, 20, 32'h20);
    step();
    wr_en = '0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int n = 0; n < 10; n++) step();
    rd(0, 4);
    rd(1, 20);
    #1;
    check("mid_a_4",    64'(rd_a[31:0]),  64'd0);
    check("mid_a_20",   64'(rd_a[63:32]), 64'h20);
    check("mid_busy_a", 64'(busy_a),      64'd1);
    reset = 1'b0;
    #1;
    check("rstmid_busy_a", 64'(busy_a),      64'd0);
    check("rstmid_done_a", 64'(done_a),      64'd0);
    check("rstmid_a_20",   64'(rd_a[63:32]), 64'd0);
    check("rstmid_rd_c",   rd_c,             64'd0);
    step();
    reset = 1'b1;
    cnt_busy_a = 0;
    cnt_done_a = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy_a) cnt_busy_a++;
      if (done_a) cnt_done_a++;
      step();
    end
    check("post_busy_a", 64'(cnt_busy_a), 64'd0);
    check("post_done_a", 64'(cnt_done_a), 64'd0);
    #1;
    check("post_a_20", 64'(rd_a[63:32]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
